stopwatch_lap_timer: RTL
========================

Name: stopwatch_lap_timer

Overview:
Parametrised successor to the team's stopwatch. It adds a programmable tick prescaler, a configurable minute range, lap capture, overflow handling and a compile-time countdown mode. It is a self-contained timing core fed by debounced single-cycle command strobes. Its outputs drive display and status logic.

Parameters:
TICK_DIV, 4, clock cycles per one-second tick while running (>=1; 1 = advance every running cycle)
MIN_W, 8, minutes output width
MAX_MIN, 99, highest minute value; must satisfy MAX_MIN < 2**MIN_W
SATURATE, 0, 0 = wrap MAX_MIN:59 -> 00:00; 1 = hold at MAX_MIN:59 and enter DONE

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  start/resume command
stop  in  1  pause command
reset  in  1  synchronous clear command
lap  in  1  lap capture command
minutes  out  MIN_W  current minutes
seconds  out  6  current seconds, 0..59
status  out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 DONE
tick  out  1  one-cycle pulse on every time update
lap_minutes  out  MIN_W  captured minutes
lap_seconds  out  6  captured seconds
lap_valid  out  1  one-cycle pulse when a capture occurs

Behaviour:
- Reset: rst_n low clears all outputs to 0 asynchronously; status = IDLE; prescaler = 0.
- Commands are sampled every rising edge. A command held high is re-evaluated each cycle; the effect is idempotent.
- Command priority: reset > load (countdown build) > stop > start.
- State transitions:
  - Any state + reset -> IDLE: time 00:00, prescaler 0, lap regs 0.
  - IDLE + start -> RUNNING.
  - PAUSED + start -> RUNNING.
  - RUNNING + stop -> PAUSED.
  - start with stop in the same cycle: stop wins; in IDLE nothing happens.
  - DONE ignores start, stop and lap; only reset leaves DONE.
- Timing: a command sampled at edge N is visible on status after edge N.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while RUNNING; holds its value in PAUSED.
  - On terminal count it wraps to 0, the time advances, and tick pulses in the same cycle the new time appears.
  - The first advance occurs TICK_DIV cycles after entering RUNNING from IDLE.
- Up count: seconds 59 -> 0 with minutes +1.
- Up-count overflow at MAX_MIN:59:
  - SATURATE=0: next tick gives 00:00; state stays RUNNING.
  - SATURATE=1: time holds, status -> DONE, tick is not pulsed.
- Lap:
  - In RUNNING or PAUSED, lap captures the time present before this edge's update into lap regs and pulses lap_valid the next cycle.
  - Ignored in IDLE and DONE.
  - A lap in the same cycle as reset is discarded.
- Reset mid-tick: the prescaler clears; no tick is emitted.

Optional Feature:
STOPWATCH_COUNTDOWN_EN.
With the macro defined:
- Extra ports: count_down in 1, load in 1, load_minutes in MIN_W, load_seconds in 6, done out 1.
- load is honoured only in IDLE. It presets the time, clamping seconds > 59 to 59 and minutes > MAX_MIN to MAX_MIN.
- count_down is latched on IDLE->RUNNING and held until the next IDLE.
- Down count: seconds 0 -> 59 with minutes -1.
- The tick that reaches 00:00 sets status DONE and pulses done for one cycle, coincident with tick.
- Start from IDLE at 00:00 in down mode -> DONE after one edge, with done pulsed.
- reset returns to 00:00; the preset is not retained.
Without the macro: those ports are absent and counting is up-only.

Decomposition:
- Package stopwatch_pkg: status encodings (ST_IDLE, ST_RUNNING, ST_PAUSED, ST_DONE), SEC_MAX = 59, 2-bit status typedef.
- Sub-module stopwatch_prescaler (parameter TICK_DIV; inputs enable, clear; output tick).
- The FSM, time arithmetic and lap registers stay in the top module.

Test Plan:
1. Reset release, start at cycle 2, TICK_DIV=4 -> status 01 next edge; seconds 1 at 4 cycles after start, 3 after 12 cycles.
2. Run to 00:02, stop, wait 20 cycles, start -> time frozen at 00:02 while status 10; prescaler resumes its partial count; 00:03 on schedule.
3. start+stop same cycle in RUNNING -> status 10; reset+lap in PAUSED -> status 00, time 00:00, lap_valid stays 0.
4. MAX_MIN=1: run past 01:59 -> SATURATE=0 gives 00:00 and RUNNING; SATURATE=1 holds 01:59 with status 11 and no further tick.
5. Lap at 00:05 in RUNNING -> lap_seconds 5 and lap_valid for exactly 1 cycle; lap in IDLE -> no pulse.
6. (COUNTDOWN_EN) load 00:03 (load_seconds 70 clamps to 59 check separately), count_down=1, start -> 00:02, 00:01, 00:00; done pulse and status 11 on the last tick.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch / lap timer core: status encodings,
// the seconds terminal value and a small clamping helper used by the preset
// path of the countdown build (STOPWATCH_COUNTDOWN_EN).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_DONE    = 2'b11
    } status_t;

    localparam logic [5:0] SEC_MAX = 6'd59;

    // Limit a seconds value to the displayable range 0..59.
    function automatic logic [5:0] clamp_sec(input logic [5:0] s);
        logic [5:0] r;
        if (s > SEC_MAX) begin
            r = SEC_MAX;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_prescaler.sv
// One-second tick prescaler. Counts 0..TICK_DIV-1 while enabled, holds its
// partial count while disabled, and flags the terminal count combinationally
// so the owner can update time on the same edge the counter wraps.
module stopwatch_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tc_s;

    // Terminal count: this enabled cycle completes one tick period.
    always_comb begin
        tc_s = 1'b0;
        if (enable && (cnt_r == TC)) begin
            tc_s = 1'b1;
        end else begin
            tc_s = 1'b0;
        end
    end

    // Cycle counter: clear wins, wraps at terminal count, holds when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (tc_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = tc_s;

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch / lap timer core. Control FSM, mm:ss arithmetic and lap capture
// live here; the tick period comes from stopwatch_prescaler.
// Optional countdown mode (load/preset, down counting, done pulse) is built
// when the macro STOPWATCH_COUNTDOWN_EN is defined; otherwise up-count only.
module stopwatch_lap_timer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int MIN_W    = 8,
    parameter int MAX_MIN  = 99,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             reset,
    input  logic             lap,
`ifdef STOPWATCH_COUNTDOWN_EN
    input  logic             count_down,
    input  logic             load,
    input  logic [MIN_W-1:0] load_minutes,
    input  logic [5:0]       load_seconds,
    output logic             done,
`endif
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic [1:0]       status,
    output logic             tick,
    output logic [MIN_W-1:0] lap_minutes,
    output logic [5:0]       lap_seconds,
    output logic             lap_valid
);

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);
    localparam logic [MIN_W-1:0] MIN_ZERO  = {MIN_W{1'b0}};

    status_t          state_r, nxt_state_s;
    logic [MIN_W-1:0] min_r, nxt_min_s;
    logic [5:0]       sec_r, nxt_sec_s;
    logic             tick_r, nxt_tick_s;
    logic [MIN_W-1:0] lap_min_r, nxt_lap_min_s;
    logic [5:0]       lap_sec_r, nxt_lap_sec_s;
    logic             lap_valid_r, nxt_lap_valid_s;
    logic             fin_s;
    logic             pre_tick_s;
    logic             run_s;
`ifdef STOPWATCH_COUNTDOWN_EN
    logic             down_r, nxt_down_s;
    logic             done_r, nxt_done_s;
`endif

    assign run_s = (state_r == ST_RUNNING);

    stopwatch_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (run_s),
        .clear  (reset),
        .tick   (pre_tick_s)
    );

    // Next state, next time value, lap capture and pulse generation.
    always_comb begin
        nxt_state_s     = state_r;
        nxt_min_s       = min_r;
        nxt_sec_s       = sec_r;
        nxt_tick_s      = 1'b0;
        nxt_lap_min_s   = lap_min_r;
        nxt_lap_sec_s   = lap_sec_r;
        nxt_lap_valid_s = 1'b0;
        fin_s           = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
        nxt_down_s      = down_r;
        nxt_done_s      = 1'b0;
`endif
        if (reset) begin
            // Clear command dominates everything, including a coincident lap.
            nxt_state_s   = ST_IDLE;
            nxt_min_s     = MIN_ZERO;
            nxt_sec_s     = 6'd0;
            nxt_lap_min_s = MIN_ZERO;
            nxt_lap_sec_s = 6'd0;
`ifdef STOPWATCH_COUNTDOWN_EN
            nxt_down_s    = 1'b0;
`endif
        end else begin
            // Lap captures the pre-update time; the pulse appears next cycle.
            if (lap && ((state_r == ST_RUNNING) || (state_r == ST_PAUSED))) begin
                nxt_lap_min_s   = min_r;
                nxt_lap_sec_s   = sec_r;
                nxt_lap_valid_s = 1'b1;
            end else begin
                nxt_lap_valid_s = 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
`ifdef STOPWATCH_COUNTDOWN_EN
                    if (load) begin
                        nxt_sec_s = clamp_sec(load_seconds);
                        if (load_minutes > MAX_MIN_V) begin
                            nxt_min_s = MAX_MIN_V;
                        end else begin
                            nxt_min_s = load_minutes;
                        end
                    end else if (stop) begin
                        nxt_state_s = ST_IDLE;
                    end else if (start) begin
                        nxt_down_s = count_down;
                        // Counting down from 00:00 has nothing to do.
                        if (count_down && (min_r == MIN_ZERO) && (sec_r == 6'd0)) begin
                            nxt_state_s = ST_DONE;
                            nxt_done_s  = 1'b1;
                        end else begin
                            nxt_state_s = ST_RUNNING;
                        end
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
`else
                    if (stop) begin
                        nxt_state_s = ST_IDLE;
                    end else if (start) begin
                        nxt_state_s = ST_RUNNING;
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
`endif
                end

                ST_RUNNING: begin
                    if (pre_tick_s) begin
`ifdef STOPWATCH_COUNTDOWN_EN
                        if (down_r) begin
                            if (sec_r == 6'd0) begin
                                if (min_r == MIN_ZERO) begin
                                    fin_s      = 1'b1;
                                    nxt_done_s = 1'b1;
                                end else begin
                                    nxt_min_s  = min_r - MIN_W'(1'b1);
                                    nxt_sec_s  = SEC_MAX;
                                    nxt_tick_s = 1'b1;
                                end
                            end else begin
                                nxt_sec_s  = sec_r - 6'd1;
                                nxt_tick_s = 1'b1;
                                // Reaching 00:00 finishes the countdown on this tick.
                                if ((min_r == MIN_ZERO) && (sec_r == 6'd1)) begin
                                    fin_s      = 1'b1;
                                    nxt_done_s = 1'b1;
                                end else begin
                                    fin_s      = 1'b0;
                                end
                            end
                        end else begin
`endif
                        if (sec_r == SEC_MAX) begin
                            if (min_r == MAX_MIN_V) begin
                                if (SATURATE != 0) begin
                                    // Hold at the top value; no tick.
                                    fin_s = 1'b1;
                                end else begin
                                    nxt_min_s  = MIN_ZERO;
                                    nxt_sec_s  = 6'd0;
                                    nxt_tick_s = 1'b1;
                                end
                            end else begin
                                nxt_min_s  = min_r + MIN_W'(1'b1);
                                nxt_sec_s  = 6'd0;
                                nxt_tick_s = 1'b1;
                            end
                        end else begin
                            nxt_sec_s  = sec_r + 6'd1;
                            nxt_tick_s = 1'b1;
                        end
`ifdef STOPWATCH_COUNTDOWN_EN
                        end
`endif
                    end else begin
                        nxt_tick_s = 1'b0;
                    end

                    // Finishing outranks a pause requested on the same edge.
                    if (fin_s) begin
                        nxt_state_s = ST_DONE;
                    end else if (stop) begin
                        nxt_state_s = ST_PAUSED;
                    end else begin
                        nxt_state_s = ST_RUNNING;
                    end
                end

                ST_PAUSED: begin
                    if (stop) begin
                        nxt_state_s = ST_PAUSED;
                    end else if (start) begin
                        nxt_state_s = ST_RUNNING;
                    end else begin
                        nxt_state_s = ST_PAUSED;
                    end
                end

                ST_DONE: begin
                    nxt_state_s = ST_DONE;
                end

                default: begin
                    nxt_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Time, lap and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_r       <= MIN_ZERO;
            sec_r       <= 6'd0;
            tick_r      <= 1'b0;
            lap_min_r   <= MIN_ZERO;
            lap_sec_r   <= 6'd0;
            lap_valid_r <= 1'b0;
        end else begin
            min_r       <= nxt_min_s;
            sec_r       <= nxt_sec_s;
            tick_r      <= nxt_tick_s;
            lap_min_r   <= nxt_lap_min_s;
            lap_sec_r   <= nxt_lap_sec_s;
            lap_valid_r <= nxt_lap_valid_s;
        end
    end

`ifdef STOPWATCH_COUNTDOWN_EN
    // Count direction latch and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            down_r <= nxt_down_s;
            done_r <= nxt_done_s;
        end
    end

    assign done = done_r;
`endif

    assign minutes     = min_r;
    assign seconds     = sec_r;
    assign status      = state_r;
    assign tick        = tick_r;
    assign lap_minutes = lap_min_r;
    assign lap_seconds = lap_sec_r;
    assign lap_valid   = lap_valid_r;

endmodule
